regfile_mp: RTL and testbench

- Parametrised multi-port integer register file with a per-register busy scoreboard, for the dual-issue core.
- Serves NR combinational read ports and NW write-back ports.
- Tracks pending writes reserved at issue, so the issue stage can stall on RAW hazards.
- Register 0 is hardwired to zero.

---
 rtl/regfile_mp.sv | 108 ++++++++++
 tb/tb_regfile_mp.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard; x0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy-clear to the read ports.

module regfile_mp_rd #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NW   = 2,
  parameter int AW   = 5
) (
  output logic [XLEN-1:0]            rdata_o,
  output logic                       rbusy_o,
`ifdef REGFILE_BYPASS_EN
  input  logic                       rst_i,
  input  logic [NW-1:0]              wen_i,
  input  logic [NW*AW-1:0]           waddr_i,
  input  logic [NW*XLEN-1:0]         wdata_i,
  input  logic                       rsv_en_i,
  input  logic [AW-1:0]              rsv_addr_i,
`endif
  input  logic [AW-1:0]              raddr_i,
  input  logic [NREG-1:0][XLEN-1:0]  regs_i,
  input  logic [NREG-1:0]            busy_i
);

  always_comb begin
    rdata_o = regs_i[raddr_i];
    rbusy_o = busy_i[raddr_i];
`ifdef REGFILE_BYPASS_EN
    // Later ports overwrite earlier hits so the highest-indexed writer wins.
    if (!rst_i && raddr_i != '0) begin
      for (int j = 0; j < NW; j++) begin
        if (wen_i[j] && waddr_i[j*AW +: AW] == raddr_i) begin
          rdata_o = wdata_i[j*XLEN +: XLEN];
          rbusy_o = rsv_en_i && (rsv_addr_i == raddr_i);
        end
      end
    end
`endif
  end

endmodule

module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NR   = 4,
  parameter int NW   = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NR*AW-1:0]   raddr,
  output logic [NR*XLEN-1:0] rdata,
  output logic [NR-1:0]      rbusy,
  input  logic [NW-1:0]      wen,
  input  logic [NW*AW-1:0]   waddr,
  input  logic [NW*XLEN-1:0] wdata,
  input  logic               rsv_en,
  input  logic [AW-1:0]      rsv_addr,
  input  logic               flush
);

  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREG-1:0]           busy_q, busy_d;

  // Busy priority is encoded by assignment order: write-clear, then reserve, then flush.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NW; j++) begin
      if (wen[j] && waddr[j*AW +: AW] != '0) begin
        regs_d[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
        busy_d[waddr[j*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_en && rsv_addr != '0) busy_d[rsv_addr] = 1'b1;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    regfile_mp_rd #(.XLEN(XLEN), .NREG(NREG), .NW(NW), .AW(AW)) u_rd (
      .rdata_o    (rdata[i*XLEN +: XLEN]),
      .rbusy_o    (rbusy[i]),
`ifdef REGFILE_BYPASS_EN
      .rst_i      (rst),
      .wen_i      (wen),
      .waddr_i    (waddr),
      .wdata_i    (wdata),
      .rsv_en_i   (rsv_en),
      .rsv_addr_i (rsv_addr),
`endif
      .raddr_i    (raddr[i*AW +: AW]),
      .regs_i     (regs_q),
      .busy_i     (busy_q)
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp: stimulus queues expected reads, a monitor compares.

module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NR   = 4;
  localparam int NW   = 2;
  localparam int AW   = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR*AW-1:0]   raddr;
  logic [NR*XLEN-1:0] rdata;
  logic [NR-1:0]      rbusy;
  logic [NW-1:0]      wen;
  logic [NW*AW-1:0]   waddr;
  logic [NW*XLEN-1:0] wdata;
  logic               rsv_en;
  logic [AW-1:0]      rsv_addr;
  logic               flush;

  regfile_mp #(.XLEN(XLEN), .NREG(32), .NR(NR), .NW(NW)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          port;
    logic [31:0] d;
    logic        b;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  event chk_ev;

  always begin
    @(negedge clk or chk_ev);
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] ad;
      e = q.pop_front();
      ad = rdata[e.port*XLEN +: XLEN];
      n_cmp++;
      if (ad !== e.d) begin
        n_err++;
        $display("FAIL %s rdata[%0d]: got %h want %h", e.nm, e.port, ad, e.d);
      end
      n_cmp++;
      if (rbusy[e.port] !== e.b) begin
        n_err++;
        $display("FAIL %s rbusy[%0d]: got %b want %b", e.nm, e.port, rbusy[e.port], e.b);
      end
    end
  end

  task automatic idle();
    wen = '0; waddr = '0; wdata = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0; raddr = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
    wen[p] = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*XLEN +: XLEN] = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en = 1'b1;
    rsv_addr = a;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic ex(input string nm, input int p, input logic [31:0] d, input logic b);
    exp_t e;
    e.nm = nm; e.port = p; e.d = d; e.b = b;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rd(0, 5); rd(1, 3); rd(2, 7); rd(3, 9);
    for (int p = 0; p < NR; p++) ex("rst_init", p, 32'h0, 1'b0);
    @(negedge clk); #1;
    rst = 1'b0;

    // basic write/read and x0 write ignore
    step(); wr(0, 3, 32'h12345678); wr(1, 0, 32'hFFFFFFFF);
    step(); rd(2, 3); ex("wr_x3", 2, 32'h12345678, 1'b0);
            rd(1, 0); ex("wr_x0", 1, 32'h0, 1'b0);

    // same-address collision: port 1 wins
    step(); wr(0, 7, 32'hAAAA0000); wr(1, 7, 32'h0000BBBB);
    step(); rd(3, 7); ex("collide", 3, 32'h0000BBBB, 1'b0);

    // scoreboard
    step(); rsv(9);
    step(); rd(0, 9); ex("rsv_x9", 0, 32'h0, 1'b1);
    step(); wr(0, 9, 32'h99);
    step(); rd(0, 9); ex("wr_clr", 0, 32'h99, 1'b0);
    step(); rsv(9); wr(1, 9, 32'h1234);
    step(); rd(0, 9); ex("rsv_wr", 0, 32'h1234, 1'b1);
    step(); rsv(0);
    step(); rd(0, 0); ex("rsv_x0", 0, 32'h0, 1'b0);
            rd(1, 9); ex("x9_hold", 1, 32'h1234, 1'b1);

    // flush
    step(); rsv(1);
    step(); rsv(2);
    step(); rsv(4);
    step(); rd(0, 1); ex("busy_x1", 0, 32'h0, 1'b1);
            rd(1, 2); ex("busy_x2", 1, 32'h0, 1'b1);
            rd(2, 4); ex("busy_x4", 2, 32'h0, 1'b1);
            rd(3, 9); ex("busy_x9", 3, 32'h1234, 1'b1);
    step(); flush = 1'b1; rsv(6); wr(0, 4, 32'h55);
    step(); rd(0, 1); ex("flush_x1", 0, 32'h0, 1'b0);
            rd(1, 2); ex("flush_x2", 1, 32'h0, 1'b0);
            rd(2, 4); ex("flush_x4", 2, 32'h55, 1'b0);
            rd(3, 6); ex("flush_x6", 3, 32'h0, 1'b0);
    step(); rd(0, 9); ex("flush_x9", 0, 32'h1234, 1'b0);

    // bypass vs registered read
    step(); wr(0, 10, 32'h11111111);
    step(); wr(0, 10, 32'hCAFEF00D); rsv(10); rd(0, 10);
`ifdef REGFILE_BYPASS_EN
            ex("byp_same", 0, 32'hCAFEF00D, 1'b1);
`else
            ex("byp_same", 0, 32'h11111111, 1'b0);
`endif
    step(); rd(0, 10); ex("byp_next", 0, 32'hCAFEF00D, 1'b1);

    // asynchronous reset mid-cycle
    step(); wr(0, 5, 32'hDEADBEEF); rsv(8);
    step(); rd(0, 5); ex("pre_x5", 0, 32'hDEADBEEF, 1'b0);
            rd(1, 8); ex("pre_x8", 1, 32'h0, 1'b1);
            rd(2, 3); ex("pre_x3", 2, 32'h12345678, 1'b0);
            rd(3, 10); ex("pre_x10", 3, 32'hCAFEF00D, 1'b1);
    @(negedge clk); #2;
    rst = 1'b1;
    wr(1, 11, 32'h77); rsv(12);
    #1;
    for (int p = 0; p < NR; p++) ex("rst_async", p, 32'h0, 1'b0);
    ->chk_ev;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    step(); rd(0, 11); ex("rst_drop_wr", 0, 32'h0, 1'b0);
            rd(1, 12); ex("rst_drop_rsv", 1, 32'h0, 1'b0);
            rd(2, 5);  ex("rst_x5", 2, 32'h0, 1'b0);
            rd(3, 8);  ex("rst_x8", 3, 32'h0, 1'b0);

    @(negedge clk); #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
